// File: rtl/tick_rate_pkg.sv
// Shared definitions for the tick rate scheduler.
//   SPD_*   : speed codes carried on speed_sel (3 is never driven)
//   state_t : scheduler FSM states
//   div_of  : clock cycles per tick period for a speed code
//   spd_step: one saturating step of a speed code up or down
package tick_rate_pkg;

  localparam logic [1:0] SPD_SLOW = 2'd0;
  localparam logic [1:0] SPD_MID  = 2'd1;
  localparam logic [1:0] SPD_FAST = 2'd2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  function automatic int unsigned div_of(logic [1:0] code, int unsigned clk_hz,
                                         int unsigned slow_hz, int unsigned mid_hz,
                                         int unsigned fast_hz);
    case (code)
      SPD_MID:  return clk_hz / mid_hz;
      SPD_FAST: return clk_hz / fast_hz;
      default:  return clk_hz / slow_hz;
    endcase
  endfunction

  function automatic logic [1:0] spd_step(logic [1:0] cur, logic up);
    if (up) begin
      return (cur >= SPD_FAST) ? SPD_FAST : cur + 2'd1;
    end
    return (cur == SPD_SLOW) ? SPD_SLOW : cur - 2'd1;
  endfunction

endpackage

// File: rtl/tick_rate_ctrl_if.sv
// Request/status bundle of the tick rate scheduler.
//   speed_up, speed_down : 1-cycle request pulses (master -> slave)
//   pause                : level, freezes tick generation (master -> slave)
//   tick                 : 1-cycle enable at the applied rate (slave -> master)
//   speed_sel            : applied speed code (slave -> master)
//   switch_pend          : a speed change is latched, not yet applied (slave -> master)
interface tick_rate_ctrl_if;
  logic       speed_up;
  logic       speed_down;
  logic       pause;
  logic       tick;
  logic [1:0] speed_sel;
  logic       switch_pend;

  modport master (
    output speed_up, speed_down, pause,
    input  tick, speed_sel, switch_pend
  );

  modport slave (
    input  speed_up, speed_down, pause,
    output tick, speed_sel, switch_pend
  );
endinterface

// File: rtl/tick_divider.sv
// Period counter for the tick scheduler.
//   clk_in : system clock
//   rst    : asynchronous active-high reset
//   en     : count enable; low holds the count (clean freeze)
//   lim    : period length in cycles (>= 2)
//   wrap   : combinational, high on the last cycle of a period while enabled
module tick_divider #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W:0]   lim,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // lim is one bit wider than the counter so a power-of-two period still fits.
  assign wrap = en && ({1'b0, cnt_q} == (lim - (CNT_W + 1)'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_rate_ctrl.sv
// Rate scheduler: emits a registered 1-cycle tick at one of three rates and sequences
// speed changes so they only take effect on a tick boundary.
//   clk_in : system clock
//   rst    : asynchronous active-high reset
//   bus    : tick_rate_ctrl_if slave (speed_up/speed_down/pause in;
//            tick/speed_sel/switch_pend out)
module tick_rate_ctrl
  import tick_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SLOW_HZ = 2,
  parameter int unsigned MID_HZ  = 10,
  parameter int unsigned FAST_HZ = 30
) (
  input  logic             clk_in,
  input  logic             rst,
  tick_rate_ctrl_if.slave  bus
);

  localparam int unsigned DIV_SLOW = CLK_HZ / SLOW_HZ;
  localparam int unsigned CNT_W    = $clog2(DIV_SLOW);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] target_q, target_d;
  logic       pend_q, pend_d;
  logic       tick_q;

  logic [CNT_W:0] lim;
  logic           div_en;
  logic           wrap;
  logic           apply;
  logic           req_valid;
  logic [1:0]     req_cur;
  logic [1:0]     req_next;
  logic           req_take;

  assign lim    = (CNT_W + 1)'(div_of(sel_q, CLK_HZ, SLOW_HZ, MID_HZ, FAST_HZ));
  // Pause acts on the level directly so a wrap coinciding with pause is suppressed.
  assign div_en = !bus.pause;

  tick_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (div_en),
    .lim    (lim),
    .wrap   (wrap)
  );

  // Requests step from the pending target if one exists, else from the applied code.
  assign req_valid = bus.speed_up ^ bus.speed_down;
  assign req_cur   = pend_q ? target_q : sel_q;
  assign req_next  = spd_step(req_cur, bus.speed_up);
  assign req_take  = req_valid && (req_next != req_cur);
  assign apply     = wrap && pend_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    pend_d   = pend_q;

    if (apply) begin
      sel_d  = target_q;
      pend_d = 1'b0;
    end
    // A request in the apply cycle is judged against the newly applied code, so it
    // stays pending until the following wrap.
    if (req_take) begin
      target_d = req_next;
      pend_d   = (req_next != sel_d);
    end

    case (state_q)
      S_RUN: begin
        if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (pend_d) begin
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (!pend_d) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (!bus.pause) begin
          state_d = pend_d ? S_PEND : S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      sel_q    <= SPD_SLOW;
      target_q <= SPD_SLOW;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      pend_q   <= pend_d;
      tick_q   <= wrap;
    end
  end

  assign bus.tick        = tick_q;
  assign bus.speed_sel   = sel_q;
  assign bus.switch_pend = pend_q;

endmodule
